// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multiply/divide unit (op codes, FSM states, iteration count)
package mips_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add (multiply) or restoring-division step on a {upper, lower} accumulator
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    // Multiply adds the multiplicand into the upper half and shifts right;
    // divide shifts the remainder left and keeps the trial difference if it did not borrow.
    always_comb begin
        sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
        trial   = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        acc_out = div_mode ? (trial[WIDTH] ? {acc_in[2*WIDTH-2:0], 1'b0}
                                           : {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1})
                           : {sum, acc_in[WIDTH-1:1]};
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO; MULDIV_EARLY_OUT_EN lets multiplies finish once the multiplier is exhausted
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod_raw, prod;
    logic [WIDTH-1:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   a_in_mag, b_in_mag, quo, rem;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               in_signed, is_div;

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Input magnitudes and sign-corrected results from the finished accumulator.
    always_comb begin
        in_signed = ~op[0];
        a_in_mag  = (in_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        b_in_mag  = (in_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
        is_div    = op_q[1];
`ifdef MULDIV_EARLY_OUT_EN
        prod_raw  = acc_q >> (6'(MD_ITERS) - cnt_q);
`else
        prod_raw  = acc_q;
`endif
        prod      = (sa_q ^ sb_q) ? -prod_raw : prod_raw;
        quo       = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_in  (acc_q),
        .operand (is_div ? b_mag_q : a_mag_q),
        .div_mode(is_div),
        .acc_out (acc_step)
    );

    // Next-state and datapath control: launch, iterate, then sign-fix and commit to HI/LO.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    op_d    = op;
                    sa_d    = in_signed & operand_a[WIDTH-1];
                    sb_d    = in_signed & operand_b[WIDTH-1];
                    a_mag_d = a_in_mag;
                    b_mag_d = b_in_mag;
                    acc_d   = {{WIDTH{1'b0}}, op[1] ? a_in_mag : b_in_mag};
`ifdef MULDIV_EARLY_OUT_EN
                    if (!op[1] && b_in_mag[WIDTH-1:1] == '0) begin
                        state_d = FIX;
                        cnt_d   = 6'(MD_ITERS);
                        acc_d   = {{WIDTH{1'b0}}, b_in_mag[0] ? a_in_mag : '0};
                    end
`endif
                end else begin
                    hi_d = hi_we ? wdata : hi_q;
                    lo_d = lo_we ? wdata : lo_q;
                end
            end
            CALC: begin
                acc_d   = acc_step;
                cnt_d   = cnt_q + 6'd1;
                state_d = (cnt_q == 6'(MD_ITERS - 1)) ? FIX : CALC;
`ifdef MULDIV_EARLY_OUT_EN
                if (!is_div && (b_mag_q >> cnt_d) == '0) state_d = FIX;
`endif
            end
            FIX: begin
                hi_d    = is_div ? rem : prod[2*WIDTH-1:WIDTH];
                lo_d    = is_div ? ((b_mag_q == '0) ? '1 : quo) : prod[WIDTH-1:0];
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand latches, accumulator and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_mag_q <= '0;
            b_mag_q <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule
